hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the single-cycle load-use hazard detector in the ID stage.
- Keeps a per-register scoreboard of pending writebacks, each with a down-counter of remaining stall cycles.
- Raises `hazard_detected` while an ID-stage source depends on an unfinished producer and gates issue of the ID instruction into EXE.
- Supports configurable register count and latencies, with or without forwarding, and keeps a saturating stall-cycle performance counter.

Parameters:
- REG_ADDR_W, 5, register address width; NUM_REGS = 2**REG_ADDR_W.
- LOAD_STALL, 1, stall cycles a load's consumer needs when forwarding is enabled.
- ALU_STALL, 0, stall cycles an ALU producer's consumer needs when forwarding is enabled.
- WB_STALL, 2, stall cycles any producer's consumer needs when forwarding is disabled (register-file write-first).
- STAT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a valid instruction.
- src1_id  in  REG_ADDR_W  source 1 register.
- src2_id  in  REG_ADDR_W  source 2 register.
- is_imm  in  1  instruction uses an immediate in place of src2.
- st_or_bne  in  1  store/BNE: src2 is read even when is_imm=1.
- dest_id  in  REG_ADDR_W  destination register of the ID instruction.
- wb_en_id  in  1  ID instruction writes the register file.
- mem_r_en_id  in  1  ID instruction is a load.
- flush  in  1  ID instruction is squashed this cycle.
- stat_clr  in  1  synchronous clear of stall_count.
- hazard_detected  out  1  stall IF/ID; insert bubble into EXE.
- id_issue  out  1  ID instruction advances to EXE this cycle.
- stall_count  out  STAT_W  saturating count of stall cycles.

Behaviour:
- Reset (async, rst_n=0): all scoreboard counters = 0; stall_count = 0. Outputs then follow from state: hazard_detected = 0, id_issue = id_valid & ~flush.
- Scoreboard: cnt[r] for r = 1..NUM_REGS-1. cnt[0] does not exist and always reads as 0. Counter width = clog2(max(LOAD_STALL, ALU_STALL, WB_STALL)+1), minimum 1 bit.
- src2_used = ~is_imm | st_or_bne.
- hazard_detected (combinational from registered cnt) = id_valid & ~flush & ((cnt[src1_id] != 0) | (src2_used & cnt[src2_id] != 0)).
- id_issue = id_valid & ~flush & ~hazard_detected.
- Per clock edge, every nonzero cnt decrements by 1, floored at 0.
- On the same edge, if id_issue & wb_en_id & dest_id != 0, then cnt[dest_id] <= L. L overrides the decrement for that entry.
  - With forwarding: L = mem_r_en_id ? LOAD_STALL : ALU_STALL.
  - Without forwarding: L = WB_STALL.
- L = 0 is legal and means no dependence is recorded.
- Back-to-back producers to the same register: the newest issue overwrites cnt (WAW resolved by the newer latency).
- Stalled or flushed instructions never update the scoreboard. Flush does not clear entries of already-issued producers.
- Latency: the consumer in ID on cycle t+1 after a producer issue on cycle t sees hazard for exactly L cycles, then issues on cycle t+1+L.
- stall_count: on each edge, stat_clr ? 0 : (hazard_detected & count != max ? count+1 : count). stat_clr has priority over increment. The counter saturates at 2**STAT_W-1 and never wraps.
- rst_n asserted mid-stall: hazard drops immediately (async); the scoreboard is empty after release.

Optional Feature:
- Macro HAZARD_FORWARD_EN.
- Defined: per-type latencies LOAD_STALL / ALU_STALL; this reproduces the classic load-use-only stall.
- Undefined: WB_STALL applies to every writing instruction, for a pipeline with no forwarding paths.
- Ports are identical in both builds.

Test Plan:
- Forwarding on, defaults: issue `lw r3` (dest=3, mem_r_en=1), then `add r4,r3,r5` in ID next cycle -> hazard_detected=1 for exactly 1 cycle; id_issue=1 on the 2nd cycle; stall_count=1.
- Forwarding on: `add r3`, then consumer of r3 -> hazard_detected never asserts; stall_count stays 0.
- Forwarding off, WB_STALL=2: `add r7`, then `sub r8,r7,r1` -> 2 stall cycles, issue on the 3rd. A consumer arriving 2 cycles after the producer -> 1 stall cycle. A consumer arriving 3 cycles after -> 0 stall cycles.
- Immediate and register 0 cases:
  - `lw r0`, then consumer of r0 -> no hazard.
  - `lw r6`, then `addi` with src2_id=6 and is_imm=1 -> no hazard.
  - The same with st_or_bne=1 -> 1 stall cycle.
- Flush and stats:
  - Consumer stalled with flush=1 -> hazard_detected=0, id_issue=0, scoreboard unchanged.
  - With stall_count forced to 0xFFFF plus a further stall -> stays 0xFFFF.
  - stat_clr=1 during a stall -> 0.
- Async reset: assert rst_n=0 mid-way through a 2-cycle stall, without waiting for a clock -> hazard_detected=0 at once. After release the consumer issues with no stall.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// ID-stage RAW hazard scoreboard: per-register stall down-counters gate issue into EXE.
// Define HAZARD_FORWARD_EN for per-type latencies (load/ALU); otherwise WB_STALL applies to every writer.
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_STALL = 1,
    parameter int ALU_STALL  = 0,
    parameter int WB_STALL   = 2,
    parameter int STAT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] src1_id,
    input  logic [REG_ADDR_W-1:0] src2_id,
    input  logic                  is_imm,
    input  logic                  st_or_bne,
    input  logic [REG_ADDR_W-1:0] dest_id,
    input  logic                  wb_en_id,
    input  logic                  mem_r_en_id,
    input  logic                  flush,
    input  logic                  stat_clr,
    output logic                  hazard_detected,
    output logic                  id_issue,
    output logic [STAT_W-1:0]     stall_count
);

    localparam int NUM_REGS   = 2 ** REG_ADDR_W;
    localparam int MAX_LA     = (LOAD_STALL > ALU_STALL) ? LOAD_STALL : ALU_STALL;
    localparam int MAX_STALL  = (MAX_LA > WB_STALL) ? MAX_LA : WB_STALL;
    localparam int CNT_W      = (MAX_STALL > 0) ? $clog2(MAX_STALL + 1) : 1;

    localparam logic [CNT_W-1:0]  LOAD_LAT = CNT_W'(LOAD_STALL);
    localparam logic [CNT_W-1:0]  ALU_LAT  = CNT_W'(ALU_STALL);
    localparam logic [CNT_W-1:0]  WB_LAT   = CNT_W'(WB_STALL);
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    // Register 0 is hardwired zero, so it never gets a counter.
    logic [CNT_W-1:0]    cnt [1:NUM_REGS-1];
    logic [NUM_REGS-1:0] busy;
    logic                src2_used;
    logic                hazard;
    logic                issue;
    logic                sb_wr;
    logic [CNT_W-1:0]    new_lat;

`ifdef HAZARD_FORWARD_EN
    assign new_lat = mem_r_en_id ? LOAD_LAT : ALU_LAT;
`else
    logic unused_mem_r_en;
    assign unused_mem_r_en = mem_r_en_id;
    assign new_lat = WB_LAT;
`endif

    always_comb begin
        // NOTE: default assignment first so no path leaves busy unassigned (no latch).
        busy = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            busy[r] = (cnt[r] != '0);
        end
    end

    assign src2_used = ~is_imm | st_or_bne;
    assign hazard    = id_valid & ~flush & (busy[src1_id] | (src2_used & busy[src2_id]));
    assign issue     = id_valid & ~flush & ~hazard;
    assign sb_wr     = issue & wb_en_id & (dest_id != '0);

    assign hazard_detected = hazard;
    assign id_issue        = issue;

    // A fresh issue to a register replaces whatever is pending there (newest producer wins).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the scoreboard is flops, not RAM, and must come up empty, so every entry is reset.
            for (int r = 1; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments for all sequential state.
            for (int r = 1; r < NUM_REGS; r++) begin
                if (sb_wr && (dest_id == REG_ADDR_W'(r))) begin
                    cnt[r] <= new_lat;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - 1'b1;
                end
            end
        end
    end

    // Clear wins over increment; the count sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stat_clr) begin
            stall_count <= '0;
        end else if (hazard && (stall_count != STAT_MAX)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: ready-time model plus directed load/ALU/flush/stat/reset cases.
// Build-aware through HAZARD_FORWARD_EN, matching the DUT build.
`timescale 1ns/1ps
module tb_hazard_scoreboard;

    localparam int AW       = 5;
    localparam int SW       = 4;
    localparam int STAT_MAX = (1 << SW) - 1;
`ifdef HAZARD_FORWARD_EN
    localparam int L_LOAD = 1;
    localparam int L_ALU  = 0;
`else
    localparam int L_LOAD = 2;
    localparam int L_ALU  = 2;
`endif

    logic          clk;
    logic          rst_n;
    logic          id_valid;
    logic [AW-1:0] src1_id;
    logic [AW-1:0] src2_id;
    logic          is_imm;
    logic          st_or_bne;
    logic [AW-1:0] dest_id;
    logic          wb_en_id;
    logic          mem_r_en_id;
    logic          flush;
    logic          stat_clr;
    logic          hazard_detected;
    logic          id_issue;
    logic [SW-1:0] stall_count;

    hazard_scoreboard #(
        .REG_ADDR_W(AW), .LOAD_STALL(1), .ALU_STALL(0), .WB_STALL(2), .STAT_W(SW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .src1_id(src1_id), .src2_id(src2_id),
        .is_imm(is_imm), .st_or_bne(st_or_bne), .dest_id(dest_id), .wb_en_id(wb_en_id),
        .mem_r_en_id(mem_r_en_id), .flush(flush), .stat_clr(stat_clr),
        .hazard_detected(hazard_detected), .id_issue(id_issue), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each register is unavailable until an absolute cycle number.
    int unsigned cyc;
    int unsigned ready_at [32];
    int          m_stall;

    function automatic bit busy(input logic [AW-1:0] r);
        return (r != 0) && (ready_at[r] > cyc);
    endfunction

    function automatic bit model_hazard();
        return id_valid && !flush &&
               (busy(src1_id) || ((!is_imm || st_or_bne) && busy(src2_id)));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0;
            foreach (ready_at[i]) ready_at[i] = 0;
            m_stall = 0;
        end else begin
            automatic bit hz = model_hazard();
            if (stat_clr) m_stall = 0;
            else if (hz && m_stall < STAT_MAX) m_stall++;
            if (id_valid && !flush && !hz && wb_en_id && dest_id != 0)
                ready_at[dest_id] = cyc + 1 + (mem_r_en_id ? L_LOAD : L_ALU);
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            automatic bit mh = model_hazard();
            check("cyc_hazard", {31'd0, hazard_detected}, {31'd0, mh});
            check("cyc_issue", {31'd0, id_issue}, {31'd0, id_valid && !flush && !mh});
            check("cyc_stall_count", 32'(stall_count), 32'(m_stall));
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input bit v, input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                          input bit imm, input bit sb, input logic [AW-1:0] d,
                          input bit wb, input bit ld, input bit fl);
        id_valid = v; src1_id = s1; src2_id = s2; is_imm = imm; st_or_bne = sb;
        dest_id = d; wb_en_id = wb; mem_r_en_id = ld; flush = fl; stat_clr = 1'b0;
    endtask

    task automatic idle();
        next();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic clear_stats();
        idle();
        stat_clr = 1'b1;
    endtask

    // Producer with clean sources r1/r2 and an immediate.
    task automatic produce(input logic [AW-1:0] d, input bit ld, input bit fl);
        next();
        set_id(1, 1, 2, 1, 0, d, 1, ld, fl);
    endtask

    // Present a consumer and hold it until it issues; returns the stall cycles seen.
    task automatic run_consumer(input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                                input bit imm, input bit sb, output int stalls);
        bit done;
        next();
        set_id(1, s1, s2, imm, sb, 5'd20, 0, 0, 0);
        stalls = 0;
        done = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            #1;
            if (id_issue === 1'b1) done = 1;
            else begin
                stalls++;
                next();
            end
        end
        if (!done) check("consumer_issue_timeout", 0, 1);
    endtask

    int st;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        set_id(1, 1, 2, 0, 0, 0, 0, 0, 0);
        #12;
        rst_n = 1'b1;
        checking = 1'b1;
        #1;
        check("reset_hazard", {31'd0, hazard_detected}, 0);
        check("reset_issue", {31'd0, id_issue}, 1);
        check("reset_stall_count", 32'(stall_count), 0);

        // lw r3 ; add r4,r3,r5
        clear_stats();
        produce(5'd3, 1, 0);
        run_consumer(5'd3, 5'd5, 0, 0, st);
        check("lw_use_stalls", st, L_LOAD);
        check("lw_use_count", 32'(stall_count), L_LOAD);

        // add r3 ; consumer of r3
        clear_stats();
        produce(5'd3, 0, 0);
        run_consumer(5'd1, 5'd3, 0, 0, st);
        check("alu_use_stalls", st, L_ALU);
        check("alu_use_count", 32'(stall_count), L_ALU);

        // add r7 then sub r8,r7,r1 with 0/1/2 idle cycles between
        for (int g = 0; g < 3; g++) begin
            produce(5'd7, 0, 0);
            for (int i = 0; i < g; i++) idle();
            run_consumer(5'd7, 5'd1, 0, 0, st);
            check($sformatf("gap%0d_stalls", g), st, (L_ALU > g) ? L_ALU - g : 0);
        end

        // r0 never stalls
        produce(5'd0, 1, 0);
        run_consumer(5'd0, 5'd0, 0, 0, st);
        check("r0_stalls", st, 0);

        // addi with src2=r6 is not a dependence; store/BNE is
        produce(5'd6, 1, 0);
        run_consumer(5'd9, 5'd6, 1, 0, st);
        check("imm_src2_stalls", st, 0);
        produce(5'd6, 1, 0);
        run_consumer(5'd9, 5'd6, 1, 1, st);
        check("store_src2_stalls", st, L_LOAD);

        // Newest producer latency wins on WAW
        produce(5'd15, 1, 0);
        produce(5'd15, 0, 0);
        run_consumer(5'd15, 5'd1, 0, 0, st);
        check("waw_stalls", st, L_ALU);

        // Flushed consumer: no hazard, no issue, scoreboard keeps counting down
        produce(5'd10, 1, 0);
        next();
        set_id(1, 5'd10, 5'd1, 0, 0, 5'd20, 0, 0, 1);
        #1;
        check("flush_hazard", {31'd0, hazard_detected}, 0);
        check("flush_issue", {31'd0, id_issue}, 0);
        run_consumer(5'd10, 5'd1, 0, 0, st);
        check("after_flush_stalls", st, (L_LOAD > 1) ? L_LOAD - 1 : 0);

        // Flushed producer records nothing
        produce(5'd11, 1, 1);
        run_consumer(5'd11, 5'd1, 0, 0, st);
        check("flushed_producer_stalls", st, 0);

        // Saturation
        clear_stats();
        for (int i = 0; i < 16; i++) begin
            produce(5'd12, 1, 0);
            run_consumer(5'd12, 5'd1, 0, 0, st);
        end
        check("stall_count_saturated", 32'(stall_count), STAT_MAX);

        // stat_clr during a stall wins over the increment
        produce(5'd13, 1, 0);
        next();
        set_id(1, 5'd13, 5'd1, 0, 0, 5'd20, 0, 0, 0);
        stat_clr = 1'b1;
        #1;
        check("clr_stall_hazard", {31'd0, hazard_detected}, 1);
        next();
        stat_clr = 1'b0;
        #1;
        check("stat_clr_count", 32'(stall_count), 0);
        idle();
        idle();
        idle();

        // Async reset mid-stall
        produce(5'd14, 1, 0);
        next();
        set_id(1, 5'd14, 5'd1, 0, 0, 5'd20, 0, 0, 0);
        #1;
        check("pre_reset_hazard", {31'd0, hazard_detected}, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_hazard", {31'd0, hazard_detected}, 0);
        check("async_reset_issue", {31'd0, id_issue}, 1);
        check("async_reset_count", 32'(stall_count), 0);
        #2;
        rst_n = 1'b1;
        next();
        #1;
        check("post_reset_hazard", {31'd0, hazard_detected}, 0);
        check("post_reset_issue", {31'd0, id_issue}, 1);

        idle();
        idle();
        @(posedge clk);
        #1;
        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
